// File: rtl/qam16_pkg.sv
// rtl/qam16_pkg.sv - shared QAM16 level encodings and Gray code helpers
package qam16_pkg;

  localparam int CODE_W = 4;

  typedef enum logic [1:0] {
    L_M3 = 2'd0,
    L_M1 = 2'd1,
    L_P1 = 2'd2,
    L_P3 = 2'd3
  } level_t;

  // Level -> 2-bit Gray code; adjacent levels differ in one bit
  function automatic logic [1:0] gray2code(level_t lvl);
    logic [1:0] code;
    code = 2'b10;
    case (lvl)
      L_M3:    code = 2'b00;
      L_M1:    code = 2'b01;
      L_P1:    code = 2'b11;
      default: code = 2'b10;
    endcase
    return code;
  endfunction

  function automatic level_t code2gray(logic [1:0] code);
    level_t lvl;
    lvl = L_P3;
    case (code)
      2'b00:   lvl = L_M3;
      2'b01:   lvl = L_M1;
      2'b11:   lvl = L_P1;
      default: lvl = L_P3;
    endcase
    return lvl;
  endfunction

endpackage

// File: rtl/qam16_demap_if.sv
// rtl/qam16_demap_if.sv - filtered I/Q sample input and recovered symbol/bit outputs
interface qam16_demap_if
  import qam16_pkg::*;
#(
  parameter int DW = 19
) ();

  logic signed [DW-1:0] din_i;
  logic signed [DW-1:0] din_q;
  logic                 din_valid;
  logic [1:0]           din_error;
  logic                 align;
  logic [CODE_W-1:0]    sym_code;
  logic                 sym_valid;
  logic                 dout;
  logic                 dout_valid;
  logic                 err_flag;

  modport master (
    output din_i, din_q, din_valid, din_error, align,
    input  sym_code, sym_valid, dout, dout_valid, err_flag
  );

  modport slave (
    input  din_i, din_q, din_valid, din_error, align,
    output sym_code, sym_valid, dout, dout_valid, err_flag
  );

endinterface

// File: rtl/qam16_slicer.sv
// rtl/qam16_slicer.sv - one-axis level decision and Gray demap
module qam16_slicer
  import qam16_pkg::*;
#(
  parameter int                   DW     = 19,
  parameter logic signed [DW-1:0] THRESH = 19'sd2048
) (
  input  logic signed [DW-1:0] x,
  output logic [1:0]           bits
);

  localparam logic signed [DW-1:0] NEG_THRESH = -THRESH;

  level_t lvl;

  // Zero belongs to +1, +THRESH to +3, -THRESH to -1
  always_comb begin
    lvl = L_P1;
    if (!x[DW-1]) begin
      lvl = (x >= THRESH) ? L_P3 : L_P1;
    end else begin
      lvl = (x >= NEG_THRESH) ? L_M1 : L_M3;
    end
  end

  assign bits = gray2code(lvl);

endmodule

// File: rtl/qam16_demap.sv
// rtl/qam16_demap.sv - QAM16 symbol decimator, slicer/demapper and bit serializer
module qam16_demap
  import qam16_pkg::*;
#(
  parameter int                   DW     = 19,
  parameter int                   SPS    = 4,
  parameter int                   PHASE  = 0,
  parameter logic signed [DW-1:0] THRESH = 19'sd2048
) (
  input  logic           clk,
  input  logic           reset_n,
  qam16_demap_if.slave   bus
);

  localparam int CNT_W = $clog2(SPS);

  logic [CNT_W-1:0]  cnt;
  logic [1:0]        i_bits;
  logic [1:0]        q_bits;
  logic              strobe;
  logic [CODE_W-1:0] shreg;
  logic [1:0]        rem;

  qam16_slicer #(.DW(DW), .THRESH(THRESH)) u_slice_i (.x(bus.din_i), .bits(i_bits));
  qam16_slicer #(.DW(DW), .THRESH(THRESH)) u_slice_q (.x(bus.din_q), .bits(q_bits));

  // Decisions follow the valid-sample count, so input gaps stretch the symbol
  assign strobe = bus.din_valid && (cnt == CNT_W'(PHASE));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt            <= '0;
      bus.sym_code   <= '0;
      bus.sym_valid  <= 1'b0;
      bus.err_flag   <= 1'b0;
      bus.dout       <= 1'b0;
      bus.dout_valid <= 1'b0;
      shreg          <= '0;
      rem            <= '0;
    end else begin
      if (bus.align) begin
        cnt <= '0;
      end else if (bus.din_valid) begin
        cnt <= (cnt == CNT_W'(SPS - 1)) ? '0 : cnt + 1'b1;
      end

      bus.sym_valid <= strobe;
      if (strobe) begin
        bus.sym_code <= {i_bits, q_bits};
      end
      if (strobe && (bus.din_error != 2'b00)) begin
        bus.err_flag <= 1'b1;
      end

      // A fresh load takes priority over the final shift, keeping SPS=4 gap-free
      if (bus.sym_valid) begin
        bus.dout       <= bus.sym_code[CODE_W-1];
        shreg          <= {bus.sym_code[CODE_W-2:0], 1'b0};
        rem            <= 2'd3;
        bus.dout_valid <= 1'b1;
      end else if (rem != 2'd0) begin
        bus.dout       <= shreg[CODE_W-1];
        shreg          <= {shreg[CODE_W-2:0], 1'b0};
        rem            <= rem - 2'd1;
        bus.dout_valid <= 1'b1;
      end else begin
        bus.dout_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_qam16_demap.sv
// tb/tb_qam16_demap.sv - randomized self-checking bench for qam16_demap
module tb_qam16_demap;

  localparam int SPS   = 4;
  localparam int PHASE = 0;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  qam16_demap_if #(.DW(19)) bus ();

  qam16_demap #(
    .DW(19), .SPS(SPS), .PHASE(PHASE), .THRESH(19'sd2048)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int edge_n = 0;
  int vcount = 0;
  bit exp_sv = 1'b0;
  logic [3:0] exp_code = 4'h0;
  bit exp_err = 1'b0;
  bit bit_at[int];

  function automatic int level_of(int x);
    if (x >= 2048) return 3;
    if (x >= 0) return 1;
    if (x >= -2048) return -1;
    return -3;
  endfunction

  function automatic logic [1:0] gray_of(int lvl);
    case (lvl)
      -3:      return 2'b00;
      -1:      return 2'b01;
      1:       return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  function automatic logic signed [18:0] rnd_sample();
    int edges[9];
    logic signed [18:0] v;
    edges = '{-2049, -2048, -2047, -1, 0, 1, 2047, 2048, 2049};
    case ($urandom_range(0, 3))
      0:       v = 19'($urandom_range(0, 524287));
      1:       v = 19'(edges[$urandom_range(0, 8)]);
      default: v = 19'(int'($urandom_range(0, 8000)) - 4000);
    endcase
    return v;
  endfunction

  // Expected-event schedule: a decision publishes its code now and its bits on the next four edges
  task automatic model_edge();
    edge_n++;
    exp_sv = 1'b0;
    if (!reset_n) begin
      vcount = 0;
      exp_code = 4'h0;
      exp_err = 1'b0;
      bit_at.delete();
    end else begin
      if (bus.din_valid && vcount == PHASE) begin
        exp_code = {gray_of(level_of(int'(bus.din_i))), gray_of(level_of(int'(bus.din_q)))};
        exp_sv = 1'b1;
        for (int k = 0; k < 4; k++) bit_at[edge_n + 1 + k] = exp_code[3 - k];
        if (bus.din_error != 2'b00) exp_err = 1'b1;
      end
      if (bus.align) vcount = 0;
      else if (bus.din_valid) vcount = (vcount + 1) % SPS;
    end
  endtask

  task automatic check(string tag, logic [3:0] obs, logic [3:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s edge=%0d observed=%0h expected=%0h", tag, edge_n, obs, expv);
    end
  endtask

  task automatic tick();
    bit dv;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    dv = bit_at.exists(edge_n);
    check("sym_valid", {3'b0, bus.sym_valid}, {3'b0, exp_sv});
    check("sym_code", bus.sym_code, exp_code);
    check("dout_valid", {3'b0, bus.dout_valid}, {3'b0, dv});
    if (dv) begin
      check("dout", {3'b0, bus.dout}, {3'b0, bit_at[edge_n]});
      bit_at.delete(edge_n);
    end
    check("err_flag", {3'b0, bus.err_flag}, {3'b0, exp_err});
  endtask

  task automatic drive(logic signed [18:0] i, logic signed [18:0] q, logic v, logic [1:0] e, logic a);
    bus.din_i = i;
    bus.din_q = q;
    bus.din_valid = v;
    bus.din_error = e;
    bus.align = a;
  endtask

  task automatic send_sym(logic signed [18:0] i, logic signed [18:0] q, logic [1:0] e, bit gaps);
    for (int k = 0; k < SPS; k++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 3)) begin
          drive(rnd_sample(), rnd_sample(), 1'b0, 2'b00, 1'b0);
          tick();
        end
      end
      if (k == 0) drive(i, q, 1'b1, e, 1'b0);
      else drive(rnd_sample(), rnd_sample(), 1'b1, 2'b00, 1'b0);
      tick();
    end
  endtask

  initial begin
    int lv[4];
    int tv[6];
    lv = '{-3000, -1000, 1000, 3000};
    tv = '{-2049, -2048, -1, 0, 2047, 2048};

    // Reset held with random activity on every input
    reset_n = 1'b0;
    repeat (5) begin
      drive(rnd_sample(), rnd_sample(), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)));
      tick();
    end
    reset_n = 1'b1;

    // All 16 constellation points, back to back
    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++)
        send_sym(19'(lv[a]), 19'(lv[b]), 2'b00, 1'b0);

    // Decision boundaries on each axis
    for (int t = 0; t < 6; t++) send_sym(19'(tv[t]), 19'sd1000, 2'b00, 1'b0);
    for (int t = 0; t < 6; t++) send_sym(-19'sd1000, 19'(tv[t]), 2'b00, 1'b0);

    // Random symbols with valid gaps
    repeat (150) send_sym(rnd_sample(), rnd_sample(), 2'b00, 1'b1);

    // Realign mid-symbol
    for (int r = 0; r < 3; r++) begin
      repeat (1 + r) begin
        drive(rnd_sample(), rnd_sample(), 1'b1, 2'b00, 1'b0);
        tick();
      end
      drive(rnd_sample(), rnd_sample(), 1'b0, 2'b00, 1'b1);
      tick();
      repeat (3) send_sym(rnd_sample(), rnd_sample(), 2'b00, 1'b1);
    end

    // Error on the decision sample: flagged, still decoded, then sticky
    send_sym(19'sd3000, -19'sd1000, 2'b01, 1'b0);
    repeat (4) send_sym(rnd_sample(), rnd_sample(), 2'b00, 1'b1);

    // Reset three edges after sym_valid drops the rest of that symbol
    drive(19'sd3000, 19'sd3000, 1'b1, 2'b00, 1'b0);
    tick();
    drive(rnd_sample(), rnd_sample(), 1'b0, 2'b00, 1'b0);
    tick();
    tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    repeat (6) tick();

    send_sym(-19'sd3000, 19'sd1000, 2'b00, 1'b0);
    drive(19'sd0, 19'sd0, 1'b0, 2'b00, 1'b0);
    repeat (8) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
